// File: rtl/driver_scan_controller_pkg.sv
// rtl/driver_scan_controller_pkg.sv - shared types and constants for the driver scan controller
// Contents:
//   scan_state_e          scan sequencer FSM states
//   DEF_PIPE_LATENCY      default select-to-output latency of the downstream sequencer
//   DEF_MEM_TOP           default highest legal memory word address
//   *_LO / *_HI           memory region bounds (active dots, select words, dot words)
package driver_scan_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DRIVE  = 2'd2
  } scan_state_e;

  localparam int DEF_PIPE_LATENCY = 2;

  localparam int ACTIVE_LO = 0;
  localparam int ACTIVE_HI = 143;
  localparam int SELECT_LO = 144;
  localparam int SELECT_HI = 191;
  localparam int DOT_LO    = 192;
  localparam int DOT_HI    = 194;

  // Anything above the dot region is outside the sequencer memory map.
  localparam int DEF_MEM_TOP = DOT_HI;

endpackage

// File: rtl/driver_scan_counter.sv
// rtl/driver_scan_counter.sv - row/column dot counter with wrap and last-dot flag
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   clear            load row/col 0,0 (takes priority over advance)
//   advance          step to the next dot (col first, row on col wrap)
//   row, col         current dot index
//   last_dot         high when row and col are both MEM_LENGTH-1
module driver_scan_counter #(
  parameter int MEM_LENGTH = 48,
  parameter int IDX_W      = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             advance,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last_dot
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_LENGTH - 1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == LAST_IDX) begin
        col <= '0;
        // Advancing past the last dot rolls the whole array back to 0,0.
        row <= (row == LAST_IDX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last_dot = (row == LAST_IDX) && (col == LAST_IDX);

endmodule

// File: rtl/driver_scan_controller.sv
// rtl/driver_scan_controller.sv - dot-matrix driver scan sequencer with host memory-load port
// Ports:
//   clock, reset_n                  rising-edge clock, asynchronous active-low reset
//   enable, continuous              run scanning / restart after each frame
//   dwell_cycles                    drive cycles per phase (0 treated as 1)
//   host_wr_valid/ready/addr/data   host memory-load handshake (ready tied high)
//   mem_address, mem_write_n,
//   data_in                         sequencer write port (mem_write_n is an active-high strobe)
//   row_select, col_select          current dot
//   row_col_select                  0 row phase, 1 column phase
//   drive_valid                     sequencer outputs valid this cycle
//   busy                            scan FSM not idle
//   frame_done                      one-cycle pulse at the end of the last dot
//   wr_err                          one-cycle pulse for a write above MEM_TOP
module driver_scan_controller
  import driver_scan_controller_pkg::*;
#(
  parameter int MEM_LENGTH         = 48,
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int DWELL_WIDTH        = 8,
  parameter int PIPE_LATENCY       = DEF_PIPE_LATENCY,
  parameter int MEM_TOP            = DEF_MEM_TOP
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic                            continuous,
  input  logic [DWELL_WIDTH-1:0]          dwell_cycles,
  input  logic                            host_wr_valid,
  output logic                            host_wr_ready,
  input  logic [2*MEM_ADDRESS_LENGTH-1:0] host_wr_addr,
  input  logic [15:0]                     host_wr_data,
  output logic [2*MEM_ADDRESS_LENGTH-1:0] mem_address,
  output logic                            mem_write_n,
  output logic [15:0]                     data_in,
  output logic [MEM_ADDRESS_LENGTH-1:0]   row_select,
  output logic [MEM_ADDRESS_LENGTH-1:0]   col_select,
  output logic                            row_col_select,
  output logic                            drive_valid,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            wr_err
);

  localparam int ADDR_W = 2 * MEM_ADDRESS_LENGTH;

  // Phase counters count down to zero, so SETTLE loads latency-1 and DRIVE loads dwell-1.
  localparam logic [DWELL_WIDTH-1:0] SETTLE_INIT = DWELL_WIDTH'(PIPE_LATENCY - 1);
  localparam logic [ADDR_W-1:0]      TOP_ADDR    = ADDR_W'(MEM_TOP);

  scan_state_e            state_q, state_d;
  logic                   phase_q, phase_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [DWELL_WIDTH-1:0] eff_dwell;
  logic                   cnt_clear;
  logic                   cnt_advance;
  logic                   frame_done_d;
  logic                   last_dot;

  assign eff_dwell = (dwell_cycles == '0) ? DWELL_WIDTH'(1) : dwell_cycles;

  // ------------------------------------------------------------------
  // Scan FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      dwell_q     <= '0;
      drive_valid <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      dwell_q     <= dwell_d;
      // Status outputs are registered from the next state so they line up with it.
      drive_valid <= (state_d == ST_DRIVE);
      busy        <= (state_d != ST_IDLE);
      frame_done  <= frame_done_d;
    end
  end

  // ------------------------------------------------------------------
  // Scan FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    dwell_d      = dwell_q;
    cnt_clear    = 1'b0;
    cnt_advance  = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_SETTLE;
          phase_d   = 1'b0;
          cnt_clear = 1'b1;
          cnt_d     = SETTLE_INIT;
          dwell_d   = eff_dwell;
        end
      end

      ST_SETTLE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_DRIVE;
          cnt_d   = dwell_q - 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DRIVE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_INIT;
          dwell_d = eff_dwell;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (last_dot) begin
              frame_done_d = 1'b1;
              if (continuous) begin
                cnt_advance = 1'b1;
              end else begin
                // Stopping after a frame leaves the selects on the last dot.
                state_d = ST_IDLE;
                cnt_d   = '0;
              end
            end else begin
              cnt_advance = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  driver_scan_counter #(
    .MEM_LENGTH (MEM_LENGTH),
    .IDX_W      (MEM_ADDRESS_LENGTH)
  ) u_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .advance  (cnt_advance),
    .row      (row_select),
    .col      (col_select),
    .last_dot (last_dot)
  );

  assign row_col_select = phase_q;

  // ------------------------------------------------------------------
  // Host write path: always ready, one strobe cycle per legal write
  // ------------------------------------------------------------------
  assign host_wr_ready = 1'b1;

  logic wr_accept;
  logic wr_legal;

  assign wr_accept = host_wr_valid && host_wr_ready;
  assign wr_legal  = (host_wr_addr <= TOP_ADDR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_address <= '0;
      data_in     <= '0;
      mem_write_n <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      mem_write_n <= wr_accept && wr_legal;
      wr_err      <= wr_accept && !wr_legal;
      // Address/data only move on a legal write so a dropped one cannot disturb them.
      if (wr_accept && wr_legal) begin
        mem_address <= host_wr_addr;
        data_in     <= host_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_driver_scan_controller.sv
// tb/tb_driver_scan_controller.sv - directed self-checking bench for driver_scan_controller
module tb_driver_scan_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        continuous = 1'b0;
  logic [7:0]  dwell_cycles = 8'd1;
  logic        host_wr_valid = 1'b0;
  logic        host_wr_ready;
  logic [11:0] host_wr_addr = 12'd0;
  logic [15:0] host_wr_data = 16'd0;
  logic [11:0] mem_address;
  logic        mem_write_n;
  logic [15:0] data_in;
  logic [5:0]  row_select;
  logic [5:0]  col_select;
  logic        row_col_select;
  logic        drive_valid;
  logic        busy;
  logic        frame_done;
  logic        wr_err;

  int n_cmp = 0;
  int n_err = 0;
  int k;

  always #5 clock = ~clock;

  driver_scan_controller dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .continuous     (continuous),
    .dwell_cycles   (dwell_cycles),
    .host_wr_valid  (host_wr_valid),
    .host_wr_ready  (host_wr_ready),
    .host_wr_addr   (host_wr_addr),
    .host_wr_data   (host_wr_data),
    .mem_address    (mem_address),
    .mem_write_n    (mem_write_n),
    .data_in        (data_in),
    .row_select     (row_select),
    .col_select     (col_select),
    .row_col_select (row_col_select),
    .drive_valid    (drive_valid),
    .busy           (busy),
    .frame_done     (frame_done),
    .wr_err         (wr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " mem_address"}, 32'(mem_address), 32'd0);
    chk({tag, " data_in"}, 32'(data_in), 32'd0);
    chk({tag, " mem_write_n"}, 32'(mem_write_n), 32'd0);
    chk({tag, " drive_valid"}, 32'(drive_valid), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, " wr_err"}, 32'(wr_err), 32'd0);
    chk({tag, " row"}, 32'(row_select), 32'd0);
    chk({tag, " col"}, 32'(col_select), 32'd0);
    chk({tag, " phase"}, 32'(row_col_select), 32'd0);
  endtask

  task automatic run_to_frame_done();
    k = 0;
    for (int i = 0; i < 14000; i++) begin
      tick();
      k++;
      if (frame_done) break;
    end
  endtask

  initial begin
    // Reset values, asserted before any clock edge
    #2 reset_n = 1'b0;
    #1;
    chk_reset_outputs("reset");
    chk("reset host_wr_ready", 32'(host_wr_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle busy", 32'(busy), 32'd0);

    // Legal write 150 / A5A5
    host_wr_valid = 1'b1; host_wr_addr = 12'd150; host_wr_data = 16'hA5A5;
    tick();
    chk("wr150 strobe", 32'(mem_write_n), 32'd1);
    chk("wr150 addr", 32'(mem_address), 32'd150);
    chk("wr150 data", 32'(data_in), 32'hA5A5);
    chk("wr150 err", 32'(wr_err), 32'd0);
    host_wr_valid = 1'b0;
    tick();
    chk("wr150 strobe end", 32'(mem_write_n), 32'd0);
    chk("wr150 addr hold", 32'(mem_address), 32'd150);

    // Illegal write 200
    host_wr_valid = 1'b1; host_wr_addr = 12'd200; host_wr_data = 16'h1111;
    tick();
    chk("wr200 err", 32'(wr_err), 32'd1);
    chk("wr200 strobe", 32'(mem_write_n), 32'd0);
    host_wr_valid = 1'b0;
    tick();
    chk("wr200 err end", 32'(wr_err), 32'd0);

    // Boundary 194 legal, 195 illegal, then back-to-back legal writes
    host_wr_valid = 1'b1; host_wr_addr = 12'd194; host_wr_data = 16'h0194;
    tick();
    chk("wr194 strobe", 32'(mem_write_n), 32'd1);
    chk("wr194 addr", 32'(mem_address), 32'd194);
    host_wr_addr = 12'd195; host_wr_data = 16'h0195;
    tick();
    chk("wr195 strobe", 32'(mem_write_n), 32'd0);
    chk("wr195 err", 32'(wr_err), 32'd1);
    chk("wr195 addr hold", 32'(mem_address), 32'd194);
    chk("wr195 data hold", 32'(data_in), 32'h0194);
    host_wr_addr = 12'd10; host_wr_data = 16'h1010;
    tick();
    chk("b2b first strobe", 32'(mem_write_n), 32'd1);
    chk("b2b first addr", 32'(mem_address), 32'd10);
    host_wr_addr = 12'd11; host_wr_data = 16'h2222;
    tick();
    chk("b2b second strobe", 32'(mem_write_n), 32'd1);
    chk("b2b second addr", 32'(mem_address), 32'd11);
    chk("b2b second data", 32'(data_in), 32'h2222);
    host_wr_valid = 1'b0;
    tick();
    chk("b2b strobe end", 32'(mem_write_n), 32'd0);

    // Dwell 3: SETTLE 2 cycles, DRIVE 3 cycles, then column phase
    enable = 1'b1; continuous = 1'b0; dwell_cycles = 8'd3;
    tick();
    chk("d3 e0 busy", 32'(busy), 32'd1);
    chk("d3 e0 valid", 32'(drive_valid), 32'd0);
    tick();
    chk("d3 e1 valid", 32'(drive_valid), 32'd0);
    tick();
    chk("d3 e2 valid", 32'(drive_valid), 32'd1);
    tick();
    chk("d3 e3 valid", 32'(drive_valid), 32'd1);
    tick();
    chk("d3 e4 valid", 32'(drive_valid), 32'd1);
    chk("d3 e4 phase", 32'(row_col_select), 32'd0);
    tick();
    chk("d3 e5 valid", 32'(drive_valid), 32'd0);
    chk("d3 e5 phase", 32'(row_col_select), 32'd1);
    enable = 1'b0;
    tick();
    chk("d3 stop busy", 32'(busy), 32'd0);

    // Full single frame, dwell 1
    enable = 1'b1; continuous = 1'b0; dwell_cycles = 8'd1;
    tick();
    chk("f1 start row", 32'(row_select), 32'd0);
    chk("f1 start col", 32'(col_select), 32'd0);
    run_to_frame_done();
    chk("f1 cycles", 32'(k), 32'd13824);
    chk("f1 busy", 32'(busy), 32'd0);
    chk("f1 valid", 32'(drive_valid), 32'd0);
    chk("f1 hold row", 32'(row_select), 32'd47);
    chk("f1 hold col", 32'(col_select), 32'd47);
    enable = 1'b0;
    tick();
    chk("f1 done pulse end", 32'(frame_done), 32'd0);
    chk("f1 idle busy", 32'(busy), 32'd0);

    // Full frame, dwell 0 (acts as 1), continuous wraps to 0,0
    enable = 1'b1; continuous = 1'b1; dwell_cycles = 8'd0;
    tick();
    run_to_frame_done();
    chk("f0 cycles", 32'(k), 32'd13824);
    chk("f0 cont busy", 32'(busy), 32'd1);
    chk("f0 cont row", 32'(row_select), 32'd0);
    chk("f0 cont col", 32'(col_select), 32'd0);
    chk("f0 cont phase", 32'(row_col_select), 32'd0);
    enable = 1'b0; continuous = 1'b0;
    tick();
    chk("f0 stop busy", 32'(busy), 32'd0);

    // Enable dropped at row 10 col 5 column phase
    enable = 1'b1; dwell_cycles = 8'd1;
    tick();
    k = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      k++;
      if (row_select == 6'd10 && col_select == 6'd5 && row_col_select && drive_valid) break;
    end
    chk("drop reach cycles", 32'(k), 32'd2915);
    enable = 1'b0;
    tick();
    chk("drop busy", 32'(busy), 32'd0);
    chk("drop valid", 32'(drive_valid), 32'd0);
    chk("drop frame_done", 32'(frame_done), 32'd0);
    chk("drop row", 32'(row_select), 32'd10);
    chk("drop col", 32'(col_select), 32'd5);

    // Reset mid-frame with a write strobe in flight
    enable = 1'b1;
    tick();
    tick();
    tick();
    host_wr_valid = 1'b1; host_wr_addr = 12'd100; host_wr_data = 16'h1234;
    tick();
    chk("rst pre strobe", 32'(mem_write_n), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_outputs("async rst");
    tick();
    chk("rst held strobe", 32'(mem_write_n), 32'd0);
    chk("rst held busy", 32'(busy), 32'd0);
    host_wr_valid = 1'b0; enable = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("post rst busy", 32'(busy), 32'd0);
    chk("post rst strobe", 32'(mem_write_n), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
